// File: rtl/des_cbc_ctrl_if.sv
// des_cbc_ctrl_if: stream handshakes, key/IV load strobes and DES core hookup for des_cbc_ctrl.
// The controller takes the slave modport; the producer/consumer side takes master.
interface des_cbc_ctrl_if;
  logic [63:0] key_in;
  logic        key_load;
  logic [63:0] iv_in;
  logic        iv_load;
  logic [63:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] des_pt;
  logic [63:0] des_key;
  logic [63:0] des_ct;
  logic        busy;

  modport slave (
    input  key_in, key_load, iv_in, iv_load, in_data, in_valid, out_ready, des_ct,
    output in_ready, out_data, out_valid, des_pt, des_key, busy
  );

  modport master (
    output key_in, key_load, iv_in, iv_load, in_data, in_valid, out_ready, des_ct,
    input  in_ready, out_data, out_valid, des_pt, des_key, busy
  );
endinterface

// File: rtl/des_cbc_ctrl.sv
// des_cbc_ctrl: clocked, back-pressured block controller around a combinational DES core.
// Define DES_CBC_EN for CBC chaining; the default build runs ECB with identical timing.
module des_cbc_ctrl #(
  parameter int unsigned CORE_WAIT = 1
) (
  input logic           clk,
  input logic           rst,
  des_cbc_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT, OUT} state_t;

  localparam logic [3:0] WAIT_LOAD = 4'(CORE_WAIT);

  state_t      state;
  state_t      state_next;
  logic [63:0] key_r;
  logic [63:0] pt_r;
  logic [63:0] out_r;
  logic [63:0] pt_next;
  logic [3:0]  cnt;
  logic        accept;
  logic        last_wait;

  assign accept    = bus.in_valid & bus.in_ready;
  assign last_wait = (cnt == 4'd1);

`ifdef DES_CBC_EN
  logic [63:0] chain_r;

  // An IV loaded in the accept cycle takes precedence over the stored chain value.
  assign pt_next = bus.in_data ^ (bus.iv_load ? bus.iv_in : chain_r);

  always_ff @(posedge clk) begin
    if (rst) begin
      chain_r <= '0;
    end else if (state == IDLE && bus.iv_load) begin
      chain_r <= bus.iv_in;
    end else if (state == WAIT && last_wait) begin
      chain_r <= bus.des_ct;
    end
  end
`else
  logic unused_iv;

  assign pt_next   = bus.in_data;
  assign unused_iv = ^{bus.iv_in, bus.iv_load};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept)        state_next = WAIT;
      WAIT:    if (last_wait)     state_next = OUT;
      OUT:     if (bus.out_ready) state_next = IDLE;
      default:                    state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state == IDLE) & ~rst;
    bus.out_valid = (state == OUT);
    bus.busy      = (state != IDLE);
  end

  // Key and plaintext only move in IDLE, so the core inputs hold still for the whole settle window.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_r <= '0;
      pt_r  <= '0;
      out_r <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.key_load) key_r <= bus.key_in;
          if (accept) begin
            pt_r <= pt_next;
            cnt  <= WAIT_LOAD;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (last_wait) out_r <= bus.des_ct;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.out_data = out_r;
  assign bus.des_pt   = pt_r;
  assign bus.des_key  = key_r;
endmodule

// File: tb/tb_des_cbc_ctrl.sv
// tb_des_cbc_ctrl: directed scoreboard bench for des_cbc_ctrl at CORE_WAIT 1 and 4.
// A stand-in core returns the known DES vector for its key/plaintext and a scrambled value otherwise.
module tb_des_cbc_ctrl;
  localparam logic [63:0] KEY_VEC = 64'h1334_5779_9BBC_DFF1;
  localparam logic [63:0] PT_VEC  = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] CT_VEC  = 64'h85E8_1354_0F0A_B405;
  localparam logic [63:0] BLK2    = 64'h84CB_5633_86A1_79EA;

  logic clk;
  logic rst;
  logic sel;
  logic [63:0] key_in, iv_in, in_data;
  logic key_load, iv_load, in_valid, out_ready;

  int compared   = 0;
  int mismatched = 0;

  logic [63:0] exp_q[$];
  logic [63:0] m_key[2];
  logic [63:0] m_chain[2];
  logic [63:0] last_pt;

  des_cbc_ctrl_if bus1();
  des_cbc_ctrl_if bus4();

  des_cbc_ctrl #(.CORE_WAIT(1)) dut  (.clk(clk), .rst(rst), .bus(bus1));
  des_cbc_ctrl #(.CORE_WAIT(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

  function automatic logic [63:0] core_fn(input logic [63:0] pt, input logic [63:0] key);
    if (pt == PT_VEC && key == KEY_VEC) return CT_VEC;
    return {pt[40:0], pt[63:41]} ^ key ^ 64'h5A3C_96E1_0F87_D24B;
  endfunction

  assign bus1.des_ct = core_fn(bus1.des_pt, bus1.des_key);
  assign bus4.des_ct = core_fn(bus4.des_pt, bus4.des_key);

  assign bus1.key_in    = key_in;
  assign bus4.key_in    = key_in;
  assign bus1.iv_in     = iv_in;
  assign bus4.iv_in     = iv_in;
  assign bus1.in_data   = in_data;
  assign bus4.in_data   = in_data;
  assign bus1.key_load  = key_load  & ~sel;
  assign bus4.key_load  = key_load  &  sel;
  assign bus1.iv_load   = iv_load   & ~sel;
  assign bus4.iv_load   = iv_load   &  sel;
  assign bus1.in_valid  = in_valid  & ~sel;
  assign bus4.in_valid  = in_valid  &  sel;
  assign bus1.out_ready = out_ready & ~sel;
  assign bus4.out_ready = out_ready &  sel;

  wire        in_ready  = sel ? bus4.in_ready  : bus1.in_ready;
  wire        out_valid = sel ? bus4.out_valid : bus1.out_valid;
  wire [63:0] out_data  = sel ? bus4.out_data  : bus1.out_data;
  wire [63:0] des_pt    = sel ? bus4.des_pt    : bus1.des_pt;
  wire [63:0] des_key   = sel ? bus4.des_key   : bus1.des_key;
  wire        busy      = sel ? bus4.busy      : bus1.busy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkVal(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Offers one block at a negedge, updates the reference model at the accepting edge.
  task automatic applyStimulus(input logic [63:0] data, input logic kl, input logic [63:0] k,
                               input logic il, input logic [63:0] iv);
    int n = 0;
    logic [63:0] pt;
    in_data  = data;
    in_valid = 1'b1;
    key_in   = k;
    key_load = kl;
    iv_in    = iv;
    iv_load  = il;
    while (in_ready !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    checkVal("accept_ready", 64'(in_ready), 64'd1);
    if (kl) m_key[sel] = k;
`ifdef DES_CBC_EN
    if (il) m_chain[sel] = iv;
    pt = data ^ m_chain[sel];
    m_chain[sel] = core_fn(pt, m_key[sel]);
`else
    pt = data;
`endif
    exp_q.push_back(core_fn(pt, m_key[sel]));
    last_pt = pt;
    @(negedge clk);
    in_valid = 1'b0;
    key_load = 1'b0;
    iv_load  = 1'b0;
    checkVal("des_pt", des_pt, pt);
    checkVal("des_key", des_key, m_key[sel]);
    checkVal("busy_after_accept", 64'(busy), 64'd1);
  endtask

  // Waits for out_valid, scores the block, completes the handshake.
  task automatic checkOutput(input int lat);
    int n = 0;
    logic [63:0] e;
    while (out_valid !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (lat >= 0) checkVal("out_latency", 64'(n), 64'(lat));
    checkVal("out_valid", 64'(out_valid), 64'd1);
    if (out_valid !== 1'b1) return;
    checkVal("scoreboard_depth", 64'(exp_q.size()), 64'd1);
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    checkVal("out_data", out_data, e);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkVal("out_valid_clear", 64'(out_valid), 64'd0);
    checkVal("in_ready_after_out", 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [63:0] held;
    sel       = 1'b0;
    rst       = 1'b1;
    key_in    = '0;
    key_load  = 1'b0;
    iv_in     = '0;
    iv_load   = 1'b0;
    in_data   = 64'hFEED_FACE_CAFE_BEEF;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    m_key     = '{default: '0};
    m_chain   = '{default: '0};

    // Reset held three cycles with in_valid asserted
    repeat (3) @(negedge clk);
    checkVal("rst_in_ready", 64'(in_ready), 64'd0);
    checkVal("rst_out_valid", 64'(out_valid), 64'd0);
    checkVal("rst_out_data", out_data, 64'd0);
    checkVal("rst_des_pt", des_pt, 64'd0);
    checkVal("rst_des_key", des_key, 64'd0);
    checkVal("rst_busy", 64'(busy), 64'd0);
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    checkVal("post_rst_busy", 64'(busy), 64'd0);
    checkVal("post_rst_des_pt", des_pt, 64'd0);

    $display("[TB] known-answer vector, zero IV");
    applyStimulus(PT_VEC, 1'b1, KEY_VEC, 1'b1, 64'd0);
    checkOutput(1);

    $display("[TB] chaining with IV 0123456789ABCDEF");
    applyStimulus(64'd0, 1'b0, 64'd0, 1'b1, PT_VEC);
    checkOutput(1);
    applyStimulus(BLK2, 1'b0, 64'd0, 1'b0, 64'd0);
    checkOutput(1);

    $display("[TB] back-pressure");
    applyStimulus(PT_VEC, 1'b0, 64'd0, 1'b1, 64'd0);
    in_data  = 64'hDEAD_BEEF_0BAD_F00D;
    in_valid = 1'b1;
    @(negedge clk);
    checkVal("bp_out_valid", 64'(out_valid), 64'd1);
    held = exp_q[0];
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkVal("bp_out_data", out_data, held);
      checkVal("bp_in_ready", 64'(in_ready), 64'd0);
      checkVal("bp_des_pt", des_pt, last_pt);
    end
    in_valid = 1'b0;
    checkOutput(-1);
    checkVal("bp_no_accept", des_pt, last_pt);

    $display("[TB] key/IV loads while busy");
    applyStimulus(PT_VEC, 1'b0, 64'd0, 1'b1, 64'd0);
    key_in   = '1;
    key_load = 1'b1;
    iv_in    = '1;
    iv_load  = 1'b1;
    @(negedge clk);
    checkVal("busy_load_key_wait", des_key, KEY_VEC);
    @(negedge clk);
    checkVal("busy_load_key_out", des_key, KEY_VEC);
    key_load = 1'b0;
    iv_load  = 1'b0;
    checkOutput(-1);
    applyStimulus(BLK2, 1'b0, 64'd0, 1'b0, 64'd0);
    checkOutput(1);

    $display("[TB] CORE_WAIT=4 instance with mid-WAIT reset");
    sel = 1'b1;
    applyStimulus(PT_VEC, 1'b1, KEY_VEC, 1'b1, 64'd0);
    checkOutput(4);
    applyStimulus(64'h1111_2222_3333_4444, 1'b0, 64'd0, 1'b0, 64'd0);
    @(negedge clk);
    checkVal("cw4_mid_busy", 64'(busy), 64'd1);
    checkVal("cw4_mid_out_valid", 64'(out_valid), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    checkVal("cw4_rst_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    exp_q.delete();
    m_key[1]   = '0;
    m_chain[1] = '0;
    checkVal("cw4_rst_busy", 64'(busy), 64'd0);
    checkVal("cw4_rst_des_pt", des_pt, 64'd0);
    checkVal("cw4_rst_des_key", des_key, 64'd0);
    checkVal("cw4_rst_out_data", out_data, 64'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkVal("cw4_no_out_valid", 64'(out_valid), 64'd0);
    end
    checkVal("cw4_idle_in_ready", 64'(in_ready), 64'd1);
    applyStimulus(PT_VEC, 1'b1, KEY_VEC, 1'b1, 64'd0);
    checkOutput(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
